// File: rtl/m8_word_sequencer.sv
// m8_word_sequencer
//
// Paces the fetch of words from a frame buffer filler. Once enabled, every
// word-rate tick produces a one-clock fetch strobe carrying the word index
// inside the current frame. Frames are counted modulo GROUPS. When enable is
// withdrawn, the current frame is always completed before going idle.
//
// Ports
//   clk          : single clock, all logic on its rising edge
//   reset        : asynchronous, active-low reset
//   enable       : level request to run frames
//   wordTick     : one-clock word-rate strobe from the rate divider
//   bufGetWord   : one-clock fetch strobe to the filler
//   bufRdPointer : word index in frame, valid while bufGetWord is high
//   cntGrp       : frame index within the group
//   dataValid    : bufGetWord delayed by one clock (filler data is valid)
//   frameStart   : bufGetWord for word 0 of a frame
//   busy         : high while arming or running
//   overrun      : sticky flag, a tick arrived while a fetch was in progress
module m8_word_sequencer #(
  parameter int WORDS  = 1024,
  parameter int GROUPS = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       wordTick,
  output logic       bufGetWord,
  output logic [9:0] bufRdPointer,
  output logic [4:0] cntGrp,
  output logic       dataValid,
  output logic       frameStart,
  output logic       busy,
  output logic       overrun
);

  localparam logic [9:0] LAST_WORD  = 10'(WORDS - 1);
  localparam logic [4:0] LAST_GROUP = 5'(GROUPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    DRAIN
  } state_t;

  state_t state;
  state_t stateNext;
  logic   fetchNext;
  logic   lastFetch;

  // The fetch of the final word of a frame is the only point at which a
  // draining sequencer may stop or resume.
  assign lastFetch = bufGetWord && (bufRdPointer == LAST_WORD);

  // Next-state and fetch decision. A tick landing on the clock where a fetch
  // strobe is already high is dropped, which also guarantees the strobe is
  // never high on two consecutive clocks.
  always_comb begin
    stateNext = state;
    fetchNext = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          stateNext = ARM;
        end
      end
      ARM: begin
        if (!enable) begin
          stateNext = IDLE;
        end else if (wordTick) begin
          stateNext = RUN;
          fetchNext = 1'b1;
        end
      end
      RUN: begin
        fetchNext = wordTick && !bufGetWord;
        if (!enable) begin
          stateNext = lastFetch ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        fetchNext = wordTick && !bufGetWord;
        if (lastFetch) begin
          stateNext = enable ? RUN : IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State, strobes and counters. The pointer advances on the clock after each
  // fetch; the frame counter advances when the pointer wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      bufGetWord   <= 1'b0;
      bufRdPointer <= 10'd0;
      cntGrp       <= 5'd0;
      dataValid    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state      <= stateNext;
      bufGetWord <= fetchNext;
      dataValid  <= bufGetWord;
      if (wordTick && bufGetWord) begin
        overrun <= 1'b1;
      end
      if (bufGetWord) begin
        if (bufRdPointer == LAST_WORD) begin
          bufRdPointer <= 10'd0;
          cntGrp       <= (cntGrp == LAST_GROUP) ? 5'd0 : cntGrp + 5'd1;
        end else begin
          bufRdPointer <= bufRdPointer + 10'd1;
        end
      end else if (state == IDLE) begin
        bufRdPointer <= 10'd0;
      end
    end
  end

  assign frameStart = bufGetWord && (bufRdPointer == 10'd0);
  assign busy       = (state == ARM) || (state == RUN);

endmodule

// File: tb/tb_m8_word_sequencer.sv
// tb_m8_word_sequencer
//
// Randomized-timing bench for m8_word_sequencer. A small transaction model
// holds the word index and frame index the next fetch must carry; every
// observed fetch is compared against it and the model then advances with
// modulo arithmetic. Scenario tasks each drive stimulus and check results.
module tb_m8_word_sequencer;

  localparam int WORDS  = 1024;
  localparam int GROUPS = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       wordTick = 1'b0;
  logic       bufGetWord;
  logic [9:0] bufRdPointer;
  logic [4:0] cntGrp;
  logic       dataValid;
  logic       frameStart;
  logic       busy;
  logic       overrun;

  m8_word_sequencer #(.WORDS(WORDS), .GROUPS(GROUPS)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .wordTick     (wordTick),
    .bufGetWord   (bufGetWord),
    .bufRdPointer (bufRdPointer),
    .cntGrp       (cntGrp),
    .dataValid    (dataValid),
    .frameStart   (frameStart),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int   tests_run = 0;
  int   tests_failed = 0;

  // Transaction model and observation counters
  int   exp_ptr = 0;
  int   exp_grp = 0;
  logic prev_get = 1'b0;
  int   cyc = 0;
  int   fetch_cnt = 0;
  int   fs_total = 0;
  int   seen297 = 0;
  int   bad_seq = 0;
  int   bad_dv = 0;
  int   bad_consec = 0;
  int   bad_fs = 0;
  int   bad_ptr = 0;
  int   bad_exp_ptr = 0;
  int   last_fs_grp = -1;
  int   grp33 = -1;
  int   last_fetch_cyc = 0;
  int   last_fetch_ptr = -1;
  int   last_fetch_grp = -1;

  // Drive one clock of wordTick, then observe the outputs at the falling edge
  // and fold them into the model.
  task automatic step(input logic tick);
    wordTick = tick;
    @(negedge clk);
    cyc++;
    if (dataValid !== prev_get) bad_dv++;
    if (frameStart !== ((bufGetWord === 1'b1) && (bufRdPointer === 10'd0))) bad_fs++;
    if (bufGetWord === 1'b1) begin
      if (prev_get === 1'b1) bad_consec++;
      fetch_cnt++;
      if (bufRdPointer !== 10'(exp_ptr) || cntGrp !== 5'(exp_grp)) begin
        if (bad_seq == 0) begin
          bad_ptr     = int'(bufRdPointer);
          bad_exp_ptr = exp_ptr;
        end
        bad_seq++;
      end
      if (bufRdPointer === 10'd297) seen297++;
      if (frameStart === 1'b1) begin
        fs_total++;
        last_fs_grp = int'(cntGrp);
        if (fs_total == 33) grp33 = int'(cntGrp);
      end
      last_fetch_cyc = cyc;
      last_fetch_ptr = int'(bufRdPointer);
      last_fetch_grp = int'(cntGrp);
      exp_ptr = (exp_ptr + 1) % WORDS;
      if (exp_ptr == 0) exp_grp = (exp_grp + 1) % GROUPS;
    end
    prev_get = bufGetWord;
  endtask

  // n ticks, each followed by a random idle gap so the period is lo..hi clks
  task automatic run_ticks(input int n, input int lo, input int hi);
    for (int i = 0; i < n; i++) begin
      step(1'b1);
      repeat (int'($urandom_range(hi, lo)) - 1) step(1'b0);
    end
  endtask

  task automatic test_reset;
    enable   = 1'b1;
    wordTick = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++; if (bufGetWord !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_get: got %b, expected 0", bufGetWord); end
    tests_run++; if (bufRdPointer !== 10'd0) begin tests_failed++; $display("[TB] FAIL reset_ptr: got %0d, expected 0", bufRdPointer); end
    tests_run++; if (cntGrp !== 5'd0) begin tests_failed++; $display("[TB] FAIL reset_grp: got %0d, expected 0", cntGrp); end
    tests_run++; if (dataValid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_dv: got %b, expected 0", dataValid); end
    tests_run++; if (frameStart !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_fs: got %b, expected 0", frameStart); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_overrun: got %b, expected 0", overrun); end
    // Release with a tick on the same edge: that tick must not fetch
    @(posedge clk);
    reset = 1'b1;
    step(1'b1);
    repeat (3) step(1'b0);
    tests_run++; if (fetch_cnt !== 0) begin tests_failed++; $display("[TB] FAIL release_tick: got %0d fetches, expected 0", fetch_cnt); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL arm_busy: got %b, expected 1", busy); end
  endtask

  task automatic test_two_frames;
    int f0, fs0, s0;
    f0 = fetch_cnt; fs0 = fs_total; s0 = seen297;
    run_ticks(2 * WORDS, 4, 4);
    tests_run++; if (fetch_cnt - f0 !== 2 * WORDS) begin tests_failed++; $display("[TB] FAIL two_frames_count: got %0d, expected %0d", fetch_cnt - f0, 2 * WORDS); end
    tests_run++; if (bad_seq !== 0) begin tests_failed++; $display("[TB] FAIL two_frames_seq: %0d bad, first ptr %0d expected %0d", bad_seq, bad_ptr, bad_exp_ptr); end
    tests_run++; if (fs_total - fs0 !== 2) begin tests_failed++; $display("[TB] FAIL two_frames_fs: got %0d, expected 2", fs_total - fs0); end
    tests_run++; if (seen297 - s0 !== 2) begin tests_failed++; $display("[TB] FAIL two_frames_297: got %0d, expected 2", seen297 - s0); end
    tests_run++; if (bad_dv !== 0) begin tests_failed++; $display("[TB] FAIL data_valid: got %0d bad clks, expected 0", bad_dv); end
    tests_run++; if (bad_fs !== 0) begin tests_failed++; $display("[TB] FAIL frame_start: got %0d bad clks, expected 0", bad_fs); end
    tests_run++; if (cntGrp !== 5'(exp_grp)) begin tests_failed++; $display("[TB] FAIL two_frames_grp: got %0d, expected %0d", cntGrp, exp_grp); end
  endtask

  task automatic test_group_wrap;
    run_ticks(30 * WORDS + 1, 2, 2);
    tests_run++; if (grp33 !== 0) begin tests_failed++; $display("[TB] FAIL grp_wrap_33: got %0d, expected 0", grp33); end
    tests_run++; if (seen297 !== 32) begin tests_failed++; $display("[TB] FAIL grp_wrap_297: got %0d, expected 32", seen297); end
    tests_run++; if (fs_total !== 33) begin tests_failed++; $display("[TB] FAIL grp_wrap_fs: got %0d, expected 33", fs_total); end
    tests_run++; if (bad_seq !== 0) begin tests_failed++; $display("[TB] FAIL grp_wrap_seq: %0d bad, first ptr %0d expected %0d", bad_seq, bad_ptr, bad_exp_ptr); end
    tests_run++; if (bad_consec !== 0) begin tests_failed++; $display("[TB] FAIL consecutive: got %0d, expected 0", bad_consec); end
  endtask

  task automatic test_drain;
    int budget, f0, grp_next, fs0;
    budget = 2 * WORDS;
    while (exp_ptr != 501 && budget > 0) begin run_ticks(1, 2, 4); budget--; end
    enable = 1'b0;
    f0 = fetch_cnt;
    budget = 2 * WORDS;
    while (exp_ptr != 0 && budget > 0) begin run_ticks(1, 2, 4); budget--; end
    tests_run++; if (budget == 0) begin tests_failed++; $display("[TB] FAIL drain_timeout: pointer got %0d, expected 0", exp_ptr); end
    grp_next = exp_grp;
    run_ticks(6, 2, 3);
    tests_run++; if (fetch_cnt - f0 !== WORDS - 501) begin tests_failed++; $display("[TB] FAIL drain_count: got %0d, expected %0d", fetch_cnt - f0, WORDS - 501); end
    tests_run++; if (last_fetch_ptr !== WORDS - 1) begin tests_failed++; $display("[TB] FAIL drain_last: got %0d, expected %0d", last_fetch_ptr, WORDS - 1); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL drain_busy: got %b, expected 0", busy); end
    tests_run++; if (bufRdPointer !== 10'd0) begin tests_failed++; $display("[TB] FAIL drain_ptr: got %0d, expected 0", bufRdPointer); end
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_tick_overrun: got %b, expected 0", overrun); end
    enable = 1'b1;
    fs0 = fs_total;
    step(1'b0);
    step(1'b0);
    run_ticks(1, 2, 2);
    tests_run++; if (fs_total - fs0 !== 1) begin tests_failed++; $display("[TB] FAIL rearm_fs: got %0d, expected 1", fs_total - fs0); end
    tests_run++; if (last_fs_grp !== grp_next) begin tests_failed++; $display("[TB] FAIL rearm_grp: got %0d, expected %0d", last_fs_grp, grp_next); end
  endtask

  task automatic test_back_to_back;
    int d, raise_at, p, budget, c1023, f0;
    d        = int'($urandom_range(1000, 700));
    raise_at = ($urandom_range(1, 0) == 1) ? 0 : int'($urandom_range(WORDS - 1, d + 1));
    p        = int'($urandom_range(4, 2));
    budget = 2 * WORDS;
    while (exp_ptr != d && budget > 0) begin run_ticks(1, 2, 4); budget--; end
    enable = 1'b0;
    budget = 2 * WORDS;
    while (budget > 0) begin
      step(1'b1);
      if (exp_ptr == raise_at) enable = 1'b1;
      repeat (p - 1) step(1'b0);
      budget--;
      if (exp_ptr == 0) break;
    end
    c1023 = last_fetch_cyc;
    f0 = fetch_cnt;
    step(1'b1);
    repeat (p - 1) step(1'b0);
    tests_run++; if (last_fetch_cyc - c1023 !== p) begin tests_failed++; $display("[TB] FAIL b2b_gap: got %0d clks, expected %0d", last_fetch_cyc - c1023, p); end
    tests_run++; if (last_fetch_ptr !== 0) begin tests_failed++; $display("[TB] FAIL b2b_ptr: got %0d, expected 0", last_fetch_ptr); end
    run_ticks(10, 2, 4);
    tests_run++; if (fetch_cnt - f0 !== 11) begin tests_failed++; $display("[TB] FAIL b2b_count: got %0d, expected 11", fetch_cnt - f0); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_busy: got %b, expected 1", busy); end
  endtask

  task automatic test_overrun;
    int f0;
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL overrun_pre: got %b, expected 0", overrun); end
    repeat (int'($urandom_range(5, 0))) step(1'b0);
    f0 = fetch_cnt;
    step(1'b1);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    tests_run++; if (fetch_cnt - f0 !== 1) begin tests_failed++; $display("[TB] FAIL overrun_fetches: got %0d, expected 1", fetch_cnt - f0); end
    tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("[TB] FAIL overrun_set: got %b, expected 1", overrun); end
    run_ticks(20, 2, 4);
    tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("[TB] FAIL overrun_sticky: got %b, expected 1", overrun); end
    tests_run++; if (bad_seq !== 0 || bad_consec !== 0) begin tests_failed++; $display("[TB] FAIL overrun_seq: got %0d/%0d bad, expected 0/0", bad_seq, bad_consec); end
  endtask

  task automatic test_reset_midframe;
    int budget, f0, fs0;
    budget = 2 * WORDS;
    while (budget > 0) begin
      step(1'b1);
      budget--;
      if (exp_ptr == 701) break;
      repeat (int'($urandom_range(3, 1))) step(1'b0);
    end
    #2;
    reset = 1'b0;
    #1;
    tests_run++; if (bufGetWord !== 1'b0) begin tests_failed++; $display("[TB] FAIL async_get: got %b, expected 0", bufGetWord); end
    tests_run++; if (bufRdPointer !== 10'd0) begin tests_failed++; $display("[TB] FAIL async_ptr: got %0d, expected 0", bufRdPointer); end
    tests_run++; if (cntGrp !== 5'd0) begin tests_failed++; $display("[TB] FAIL async_grp: got %0d, expected 0", cntGrp); end
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL async_overrun: got %b, expected 0", overrun); end
    tests_run++; if (frameStart !== 1'b0 || busy !== 1'b0 || dataValid !== 1'b0) begin tests_failed++; $display("[TB] FAIL async_misc: got fs=%b busy=%b dv=%b, expected 0 0 0", frameStart, busy, dataValid); end
    exp_ptr  = 0;
    exp_grp  = 0;
    prev_get = 1'b0;
    f0  = fetch_cnt;
    fs0 = fs_total;
    step(1'b1);
    step(1'b0);
    step(1'b1);
    @(posedge clk);
    reset = 1'b1;
    step(1'b1);
    repeat (2) step(1'b0);
    tests_run++; if (fetch_cnt !== f0) begin tests_failed++; $display("[TB] FAIL abort_strobes: got %0d fetches, expected 0", fetch_cnt - f0); end
    run_ticks(1, 2, 2);
    tests_run++; if (fs_total - fs0 !== 1 || last_fetch_ptr !== 0) begin tests_failed++; $display("[TB] FAIL restart_ptr: got ptr %0d fs %0d, expected ptr 0 fs 1", last_fetch_ptr, fs_total - fs0); end
    tests_run++; if (last_fetch_grp !== 0) begin tests_failed++; $display("[TB] FAIL restart_grp: got %0d, expected 0", last_fetch_grp); end
  endtask

  initial begin
    test_reset();
    test_two_frames();
    test_group_wrap();
    test_drain();
    test_back_to_back();
    test_overrun();
    test_reset_midframe();
    tests_run++; if (bad_dv !== 0 || bad_fs !== 0 || bad_consec !== 0) begin tests_failed++; $display("[TB] FAIL strobe_rules: got dv=%0d fs=%0d consec=%0d bad, expected 0", bad_dv, bad_fs, bad_consec); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/m8_word_sequencer.md
M8_WORD_SEQUENCER -- requirements
Module: m8_word_sequencer

Interface
REQ-001 SHALL have parameter WORDS, default 1024: words per frame; bufRdPointer counts 0..WORDS-1.
REQ-002 SHALL have parameter GROUPS, default 32: frames per group; cntGrp counts 0..GROUPS-1.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on posedge clk.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous active-low reset, acting on negedge reset.
REQ-005 SHALL have port enable, input, 1 bit: level request to run frames.
REQ-006 SHALL have port wordTick, input, 1 bit: one-clk word-rate strobe from the rate divider.
REQ-007 SHALL have port bufGetWord, output, 1 bit: one-clk fetch strobe to the filler.
REQ-008 SHALL have port bufRdPointer, output, 10 bits: word index in frame, valid while bufGetWord is high.
REQ-009 SHALL have port cntGrp, output, 5 bits: frame index in group.
REQ-010 SHALL have port dataValid, output, 1 bit: high exactly one clk after each bufGetWord, marking the filler's dataWord as valid.
REQ-011 SHALL have port frameStart, output, 1 bit: asserted together with bufGetWord when bufRdPointer==0.
REQ-012 SHALL have port busy, output, 1 bit: high in ARM and RUN states.
REQ-013 SHALL have port overrun, output, 1 bit: sticky error flag.

Function
REQ-014 SHALL implement states IDLE, ARM, RUN and DRAIN.
REQ-015 IDLE -> ARM SHALL occur on the first clk with enable=1.
REQ-016 ARM SHALL wait for wordTick, then enter RUN, with the first fetch at that same tick and bufRdPointer=0.
REQ-017 In RUN, each wordTick SHALL assert bufGetWord for exactly one clk, carrying the current bufRdPointer.
REQ-018 bufRdPointer SHALL increment on the clk after bufGetWord.
REQ-019 bufRdPointer SHALL wrap from WORDS-1 to 0; at that wrap, cntGrp SHALL increment.
REQ-020 cntGrp SHALL wrap from GROUPS-1 to 0; all arithmetic is unsigned and modulo the field width.
REQ-021 If enable falls during RUN, the state SHALL go to DRAIN; DRAIN SHALL finish the current frame, then enter IDLE after the fetch of word WORDS-1.
REQ-022 If enable=1 at the final fetch of the frame while in DRAIN, the state SHALL return to RUN with no gap and no lost tick.
REQ-023 In IDLE, bufRdPointer SHALL be held at 0 and cntGrp SHALL retain its value; the next ARM SHALL resume with the following group index.
REQ-024 A wordTick arriving on the clk where bufGetWord is already high SHALL be ignored, and overrun SHALL be set.
REQ-025 overrun SHALL clear only on reset.
REQ-026 wordTick in IDLE SHALL be ignored and SHALL NOT set overrun.
REQ-027 bufGetWord SHALL never be high on two consecutive clks.
REQ-028 dataValid SHALL be a one-clk delayed copy of bufGetWord, including the final fetch before IDLE.
REQ-029 frameStart SHALL be combinationally bufGetWord AND (bufRdPointer==0), or registered equivalently with identical timing.

Reset
REQ-030 On reset low, outputs SHALL immediately take these values: bufGetWord=0, bufRdPointer=0, cntGrp=0, dataValid=0, frameStart=0, busy=0, overrun=0; state SHALL be IDLE.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no further strobes.
REQ-032 After reset release, the first fetch SHALL occur no earlier than the first wordTick after ARM.
REQ-033 wordTick coincident with the clk of reset release SHALL NOT produce a fetch.

Verification
REQ-034 Scenario: enable=1 and wordTick every 4 clks, observed for 2 frames -> 2048 bufGetWord pulses; pointers 0..1023 twice; cntGrp 0 then 1; frameStart twice; dataValid follows every pulse by 1 clk.
REQ-035 Scenario: run 32 frames -> cntGrp returns to 0 at the 33rd frameStart; bufRdPointer=297 seen once per frame.
REQ-036 Scenario: enable dropped at pointer 500 -> fetches continue through 1023, then busy=0 and bufRdPointer=0; re-enable -> the next frameStart carries cntGrp=1.
REQ-037 Scenario: wordTick held high for 2 consecutive clks -> one bufGetWord only, overrun=1 and stays set until reset.
REQ-038 Scenario: reset pulsed low at pointer 700, cntGrp=5 -> all outputs 0 asynchronously; after release and one tick, the first fetch has pointer 0 and cntGrp 0.
REQ-039 Scenario: enable toggled low then high before the final fetch -> no gap between pointer 1023 and the next pointer 0 fetch.
